// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, fault codes, FSM states.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        F_OK       = 2'b00,
        F_MISALIGN = 2'b01,
        F_SIZE     = 2'b10,
        F_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_e;

    // Halfwords need an even offset, words need offset 0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mau_lane_mux.sv
// Big-endian lane selection: extracts/extends load data and merges sub-word store data.
module mau_lane_mux
    import mau_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lanes; offset 0 is the most significant byte.
    always_comb begin
        byte_lane = word[31:24];
        case (off)
            2'd0: byte_lane = word[31:24];
            2'd1: byte_lane = word[23:16];
            2'd2: byte_lane = word[15:8];
            2'd3: byte_lane = word[7:0];
            default: byte_lane = word[31:24];
        endcase
        half_lane = off[1] ? word[15:0] : word[31:16];
    end

    // Right-justify the lane and fill the upper bits with zero or its MSB.
    always_comb begin
        load_val = word;
        case (size)
            SZ_BYTE: load_val = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_val = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_val = word;
        endcase
    end

    // Replace only the addressed lane, keeping the rest of the read word.
    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0: store_word[31:24] = wdata[7:0];
                    2'd1: store_word[23:16] = wdata[7:0];
                    2'd2: store_word[15:8]  = wdata[7:0];
                    2'd3: store_word[7:0]   = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            SZ_HALF: begin
                if (off[1]) store_word[15:0] = wdata;
                else        store_word[31:16] = wdata;
            end
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer turning byte/half/word requests into word-aligned memory cycles.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on accept
// RD    | reading the memory word (load, or first half of read-modify-write)
// WR    | single write cycle; memory captures dm_din at the closing edge
// DONE  | one-cycle completion pulse with fault code
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 15,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          busy,
    output logic [1:0]    fault,
    output logic          dm_cs,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout,
    input  logic          mrdy
);

    localparam logic [7:0] CNT_LAST = 8'(RD_TIMEOUT - 1);

    state_e      state_q, state_d;
    fault_e      fault_q;
    logic        we_q, sext_q;
    logic [1:0]  size_q, off_q;
    // Word stores go straight from the port to dm_din, so only the sub-word part is kept.
    logic [15:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        rd_expired;
    logic [31:0] load_val, store_word;

    assign rd_expired = (cnt_q == CNT_LAST);

    mau_lane_mux u_lane_mux (
        .word       (dm_dout),
        .off        (off_q),
        .size       (size_q),
        .sign_ext   (sext_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and Moore strobes.
    always_comb begin
        state_d = state_q;
        dm_cs   = 1'b0;
        dm_rd   = 1'b0;
        dm_wr   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (size == SZ_RSVD || is_misaligned(size, addr[1:0])) state_d = DONE;
                    else if (we && size == SZ_WORD)                          state_d = WR;
                    else                                                     state_d = RD;
                end
            end
            RD: begin
                dm_cs = 1'b1;
                dm_rd = 1'b1;
                if (mrdy)            state_d = we_q ? WR : DONE;
                else if (rd_expired) state_d = DONE;
            end
            WR: begin
                dm_cs   = 1'b1;
                dm_wr   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fault = (state_q == DONE) ? fault_q : F_OK;

    // Request latch, read-wait counter, load result and write word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= F_OK;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            wdata_q <= 16'h0;
            cnt_q   <= 8'h0;
            rdata   <= 32'h0;
            dm_addr <= '0;
            dm_din  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        sext_q  <= sign_ext;
                        size_q  <= size;
                        off_q   <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        cnt_q   <= 8'h0;
                        dm_addr <= {addr[AW-1:2], 2'b00};
                        if (size == SZ_RSVD)                    fault_q <= F_SIZE;
                        else if (is_misaligned(size, addr[1:0])) fault_q <= F_MISALIGN;
                        else                                    fault_q <= F_OK;
                        if (we && size == SZ_WORD && !is_misaligned(size, addr[1:0]))
                            dm_din <= wdata;
                    end
                end
                RD: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mrdy) begin
                        if (we_q) dm_din <= store_word;
                        else      rdata  <= load_val;
                    end else if (rd_expired) begin
                        fault_q <= F_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer between the CPU datapath's MEM stage and the 4 KB big-endian word-port data memory. Converts byte, halfword and word loads and stores into word-aligned memory transactions. Sub-word stores use read-modify-write. Loads are lane-selected and zero- or sign-extended. Misaligned accesses, reserved sizes and missing mrdy are reported as faults; a faulted request never writes memory.

Parameters:
RD_TIMEOUT, 15, max cycles spent in RD waiting for mrdy before timeout fault (1..255)
AW, 32, address width passed to memory

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  request strobe from datapath; sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_ext  in  1  sign-extend loaded byte/halfword
addr  in  AW  byte address
wdata  in  32  store data, right-justified for byte/halfword
rdata  out  32  load result, held until next done
done  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
fault  out  2  valid with done: 00 ok, 01 misaligned, 10 reserved size, 11 timeout
dm_cs  out  1  data memory chip select
dm_rd  out  1  data memory read enable
dm_wr  out  1  data memory write enable
dm_addr  out  AW  word-aligned address {addr[AW-1:2],2'b00}
dm_din  out  32  write word to memory
dm_dout  in  32  read word from memory (combinational, big-endian)
mrdy  in  1  memory read data valid

Behaviour:
- Reset: state=IDLE. rdata, dm_addr, dm_din = 0. done, busy, fault, dm_cs, dm_rd, dm_wr = 0. Reset is asynchronous, so strobes drop immediately, including mid-transaction.
- Strobes are Moore decodes of the state register, so they are glitch-free:
  - RD: dm_cs=dm_rd=1
  - WR: dm_cs=dm_wr=1
  - otherwise all 0
- IDLE, req=1: latch we, size, sign_ext, addr, wdata, byte offset off=addr[1:0]. Next state:
  - size=11 -> DONE, fault=10
  - misaligned (half with off[0]=1, word with off!=0) -> DONE, fault=01
  - word store -> WR, dm_din=wdata
  - any load or sub-word store -> RD
- RD: wait counter cleared on entry and incremented each cycle.
  - mrdy=1: capture dm_dout.
    - Load: build rdata, go to DONE.
    - Sub-word store: merge into dm_din, go to WR.
  - Counter reaches RD_TIMEOUT without mrdy: go to DONE, fault=11, no write.
- WR: exactly one cycle; memory writes at the closing edge. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. A req seen in DONE is ignored; req is accepted only in IDLE.
- Lane map (big-endian):
  - Byte: off 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Half: off 0 -> [31:16], 2 -> [15:0].
- Load extraction: selected lane goes to rdata LSBs. Upper bits are the lane MSB when sign_ext=1, else 0. A word load returns dm_dout unchanged.
- Store merge: the read word has only the selected lane replaced by wdata[7:0] or wdata[15:0]; all other lanes are preserved.
- Latency in cycles from accept edge to done (mrdy immediate):
  - word load 2
  - word store 2
  - sub-word store 3
  - fault (non-timeout) 1
- rdata updates only on a successful load. Stores and faults leave it unchanged.
- Reset asserted in RD or WR before the WR closing edge: no memory write occurs.

Decomposition:
- Shared package mau_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - fault codes F_OK, F_MISALIGN, F_SIZE, F_TIMEOUT
  - state encoding IDLE, RD, WR, DONE
- One natural sub-module, mau_lane_mux: a purely combinational unit producing the extracted load value and the merged store word from (word, off, size, sign_ext, wdata). The FSM and timeout counter stay in the top.

Test Plan:
- Preload 0x10..0x13 = DE AD BE EF. Word load addr 0x10 -> dm_addr=0x10, done 2 cycles after accept, rdata=0xDEADBEEF, fault=00.
- Byte load addr 0x11:
  - sign_ext=1 -> rdata=0xFFFFFFAD
  - sign_ext=0 -> rdata=0x000000AD
  - Half load addr 0x12 sign_ext=1 -> 0xFFFFBEEF
- Byte store wdata=0x55 to 0x12 -> RD, WR, DONE (3 cycles), dm_din=0xDEAD55EF. A following word load of 0x10 returns 0xDEAD55EF.
- Faults, each with done 1 cycle after accept and dm_cs never asserted:
  - half load at 0x13 -> fault=01
  - size=11 -> fault=10
- mrdy held 0 on a load -> done after RD_TIMEOUT cycles in RD, fault=11, rdata unchanged, dm_wr never 1.
- Reset pulsed during RD of a byte store -> strobes 0 immediately, state IDLE. The memory word is unchanged on readback.
